// File: rtl/cu_pkg.sv
// Shared control-unit definitions: state codes, datapath mux encodings,
// opcodes used by next_state, and the decoded control-strobe bundle.
package cu_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_LINK     = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_AUIPC    = 4'd11;
    localparam logic [3:0] S_JALR     = 4'd12;
    localparam logic [3:0] S_EXEC_I   = 4'd13;

    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_OLDPC  = 2'd1;
    localparam logic [1:0] SRCA_RS1    = 2'd2;
    localparam logic [1:0] SRCB_RS2    = 2'd0;
    localparam logic [1:0] SRCB_IMM    = 2'd1;
    localparam logic [1:0] SRCB_FOUR   = 2'd2;
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEM     = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } cu_ctrl_t;

    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    function automatic logic is_retire_state(input logic [3:0] s);
        return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) ||
               (s == S_JAL) || (s == S_JALR);
    endfunction

endpackage

// File: rtl/cu_output_decode.sv
// Combinational decode of the control state into datapath strobes.
module cu_output_decode
    import cu_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output cu_ctrl_t   ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  ctrl.mem_req = 1'b1;
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_SUB;
            end
            S_LINK: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_JAL: begin
                ctrl.pc_write   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_AUIPC: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_JALR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALU;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/cu_state_control.sv
// Multicycle control state register with memory stall and illegal-op trap.
// Optional perf counters (cycle_cnt, instret_cnt) under CU_PERF_CNT_EN.
module cu_state_control
    import cu_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ns,
    input  logic        mem_ready,
    output logic [3:0]  state,
    output logic        mem_req,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        illegal_op
`ifdef CU_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       stall, trap;
    cu_ctrl_t   ctrl;

    assign stall = is_mem_state(state_q) && !mem_ready;
    // DECODE returning FETCH means next_state saw an opcode it does not know
    assign trap  = ((state_q == S_DECODE) && (ns == S_FETCH)) || (ns >= 4'd14);

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        if (!stall) begin
            if (trap) begin
                state_d   = S_FETCH;
                illegal_d = 1'b1;
            end else begin
                state_d = ns;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef CU_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (!stall && is_retire_state(state_q))
                instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

    cu_output_decode u_dec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign mem_req    = ctrl.mem_req;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign result_src = ctrl.result_src;

endmodule

// File: tb/tb_cu_state_control.sv
// Bench for cu_state_control: directed steps plus random ns/mem_ready,
// checked against a rule-level reference model and a strobe table.
module tb_cu_state_control;

    logic        clk = 1'b0;
    logic        reset, mem_ready;
    logic [3:0]  ns;
    logic [3:0]  state;
    logic        mem_req, mem_write, ir_write, pc_write, reg_write, illegal_op;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
`ifdef CU_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_state;
    bit          m_ill;
    int unsigned m_cyc, m_inst;
    logic [12:0] tbl [16];

    always #5 clk = ~clk;

    cu_state_control #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset(reset), .ns(ns), .mem_ready(mem_ready),
        .state(state), .mem_req(mem_req), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .illegal_op(illegal_op)
`ifdef CU_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // {mem_req, mem_write, ir_write, pc_write, reg_write, a, b, op, res}
    function automatic logic [12:0] row(bit mr, bit mw, bit pw, bit rw,
                                        int a, int b, int op, int res);
        logic [12:0] r;
        r = {mr, mw, 1'b0, pw, rw, 2'(a), 2'(b), 2'(op), 2'(res)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [12:0] e, o;
        e = tbl[m_state];
        if (m_state == 0) begin
            e[10] = mem_ready;
            e[9]  = mem_ready;
        end
        o = {mem_req, mem_write, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src};
        chk("state", 32'(state), 32'(m_state));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        chk($sformatf("strobes@s%0d", m_state), 32'(o), 32'(e));
`ifdef CU_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instret_cnt", instret_cnt, m_inst);
`endif
    endtask

    task automatic model_edge(input bit r, input int n, input bit rdy);
        bit memst, done;
        if (r) begin
            m_state = 0; m_ill = 0; m_cyc = 0; m_inst = 0;
            return;
        end
        m_cyc++;
        memst = (m_state == 0 || m_state == 3 || m_state == 5);
        done  = (m_state inside {4, 5, 7, 10, 12});
        m_ill = 0;
        if (memst && !rdy) return;
        if (done) m_inst++;
        if ((m_state == 1 && n == 0) || n >= 14) begin
            m_state = 0;
            m_ill   = 1;
        end else begin
            m_state = n;
        end
    endtask

    task automatic step(input bit r, input int n, input bit rdy);
        reset = r; ns = 4'(n); mem_ready = rdy;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge(r, n, rdy);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        tbl[0]  = row(1, 0, 0, 0, 0, 2, 0, 2);
        tbl[1]  = row(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[2]  = row(0, 0, 0, 0, 2, 1, 0, 0);
        tbl[3]  = row(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = row(0, 0, 0, 1, 0, 0, 0, 1);
        tbl[5]  = row(1, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = row(0, 0, 0, 0, 2, 0, 2, 0);
        tbl[7]  = row(0, 0, 0, 1, 0, 0, 0, 0);
        tbl[8]  = row(0, 0, 0, 0, 2, 0, 1, 0);
        tbl[9]  = row(0, 0, 0, 0, 1, 2, 0, 0);
        tbl[10] = row(0, 0, 1, 1, 0, 0, 0, 0);
        tbl[11] = row(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[12] = row(0, 0, 1, 1, 2, 1, 0, 2);
        tbl[13] = row(0, 0, 0, 0, 2, 1, 2, 0);

        reset = 1'b1; ns = 4'd1; mem_ready = 1'b1;
        @(posedge clk);
        model_edge(1, 1, 1);
        #1;

        // reset held, then release into DECODE
        step(1, 1, 1); step(1, 1, 1);
        step(0, 1, 1);
        // lw: 1 -> 2 -> 3 -> 4 -> 0
        step(0, 2, 1); step(0, 3, 1); step(0, 4, 1); step(0, 0, 1);
        // fetch stall, ns ignored while held
        step(0, 1, 0); step(0, 14, 0); step(0, 1, 0); step(0, 1, 1);
        // illegal opcode from DECODE
        step(0, 0, 1); step(0, 1, 1);
        // undefined codes from EXEC_R and EXEC_I
        step(0, 6, 1); step(0, 14, 1); step(0, 1, 1);
        step(0, 13, 1); step(0, 15, 1); step(0, 1, 1);
        // sw then reset mid MEMWRITE stall
        step(0, 2, 1); step(0, 5, 1); step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0);
        chk("state_after_reset", 32'(state), 32'd0);
        // 100 cycles after reset
        for (int i = 0; i < 100; i++) step(0, 1, 0);
`ifdef CU_PERF_CNT_EN
        chk("cycle_cnt_100", cycle_cnt, 32'd100);
`endif
        // random ns / mem_ready / occasional reset
        for (int i = 0; i < 500; i++)
            step(($urandom_range(0, 63) == 0), int'($urandom_range(0, 15)),
                 bit'($urandom_range(0, 1)));
        @(negedge clk);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
